pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 21 ++
 rtl/pipe_ctrl.sv | 95 +++++++++
 tb/tb_pipe_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared hold-level codes, FSM state encodings and default mul/div timeout for pipe_ctrl.
package pipe_ctrl_pkg;

    localparam int MULDIV_MAX_DEF = 66;
    localparam int CNT_W          = 7;

    // Hold levels: each pipeline register compares against its own threshold
    localparam logic [2:0] HOLD_RUN    = 3'd0;
    localparam logic [2:0] HOLD_PC     = 3'd1;
    localparam logic [2:0] HOLD_IFID   = 3'd2;
    localparam logic [2:0] HOLD_IDEX   = 3'd3;
    localparam logic [2:0] HOLD_EXMEM  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_MULDIV  = 2'd2,
        ST_BUSWAIT = 2'd3
    } state_t;

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: arbitrates jump flush, mul/div stall (with timeout),
// data-bus wait and load-use bubbles into a single hold level plus PC redirect.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULDIV_MAX = MULDIV_MAX_DEF,
    parameter int HOLD_W     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_req_i,
    input  logic [63:0]       jump_addr_i,
    input  logic              load_use_i,
    input  logic              muldiv_start_i,
    input  logic              muldiv_done_i,
    input  logic              bus_wait_i,
    output logic [HOLD_W-1:0] pipe_hold_en_o,
    output logic              jump_en_o,
    output logic [63:0]       jump_addr_o,
    output logic [1:0]        state_o,
    output logic              timeout_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MULDIV_MAX);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [63:0]        addr_q;
    logic [2:0]         level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (jump_en_o) addr_q <= jump_addr_i;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        level     = HOLD_RUN;
        jump_en_o = 1'b0;
        timeout_o = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (jump_req_i) begin
                    level     = HOLD_IDEX;
                    jump_en_o = 1'b1;
                    state_d   = ST_FLUSH;
                end else if (muldiv_start_i) begin
                    level   = HOLD_IDEX;
                    cnt_d   = CNT_W'(1);
                    state_d = ST_MULDIV;
                end else if (bus_wait_i) begin
                    level   = HOLD_EXMEM;
                    state_d = ST_BUSWAIT;
                end else if (load_use_i) begin
                    level = HOLD_IFID;
                end
            end
            ST_FLUSH: begin
                level   = HOLD_IDEX;
                state_d = ST_IDLE;
            end
            ST_MULDIV: begin
                if (muldiv_done_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q >= CNT_MAX) begin
                    // Unit never answered: release the pipe rather than deadlock
                    timeout_o = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    level = bus_wait_i ? HOLD_EXMEM : HOLD_IDEX;
                    cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
                end
            end
            ST_BUSWAIT: begin
                if (bus_wait_i) level = HOLD_EXMEM;
                else            state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pipe_hold_en_o = HOLD_W'(level);
    assign jump_addr_o    = jump_en_o ? jump_addr_i : addr_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: flush, mul/div done/timeout, bus wait, load-use, priority, async reset.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_req_i, load_use_i, muldiv_start_i, muldiv_done_i, bus_wait_i;
    logic [63:0] jump_addr_i;
    logic [2:0]  pipe_hold_en_o;
    logic        jump_en_o, timeout_o;
    logic [63:0] jump_addr_o;
    logic [1:0]  state_o;

    int nvec  = 0;
    int nfail = 0;

    pipe_ctrl #(.MULDIV_MAX(66), .HOLD_W(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .jump_req_i     (jump_req_i),
        .jump_addr_i    (jump_addr_i),
        .load_use_i     (load_use_i),
        .muldiv_start_i (muldiv_start_i),
        .muldiv_done_i  (muldiv_done_i),
        .bus_wait_i     (bus_wait_i),
        .pipe_hold_en_o (pipe_hold_en_o),
        .jump_en_o      (jump_en_o),
        .jump_addr_o    (jump_addr_o),
        .state_o        (state_o),
        .timeout_o      (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        jump_req_i = 0; load_use_i = 0; muldiv_start_i = 0; muldiv_done_i = 0; bus_wait_i = 0;
    endtask

    task automatic look(input string tag, input logic [2:0] lvl, input logic [1:0] st,
                        input logic jen, input logic to);
        @(negedge clk);
        chk({tag, ".level"},   {61'd0, pipe_hold_en_o}, {61'd0, lvl});
        chk({tag, ".state"},   {62'd0, state_o},        {62'd0, st});
        chk({tag, ".jump_en"}, {63'd0, jump_en_o},      {63'd0, jen});
        chk({tag, ".timeout"}, {63'd0, timeout_o},      {63'd0, to});
    endtask

    initial begin
        idle_in();
        jump_addr_i = 64'h0;
        rst = 1'b1;

        // Reset state
        look("reset", 3'd0, 2'd0, 1'b0, 1'b0);
        chk("reset.addr", jump_addr_o, 64'h0);
        tick();
        rst = 1'b0;
        tick();

        // Jump: two-cycle flush window, redirect strobe only on the first
        jump_req_i = 1; jump_addr_i = 64'h8000_0010;
        look("jump0", 3'd3, 2'd0, 1'b1, 1'b0);
        chk("jump0.addr", jump_addr_o, 64'h8000_0010);
        tick();
        jump_req_i = 0; jump_addr_i = 64'h1234;
        look("jump1", 3'd3, 2'd1, 1'b0, 1'b0);
        chk("jump1.addr_hold", jump_addr_o, 64'h8000_0010);
        tick();
        look("jump2", 3'd0, 2'd0, 1'b0, 1'b0);
        tick();

        // Mul/div with done at cycle 10; bus_wait mid-op lifts level to 4
        muldiv_start_i = 1;
        look("md.c0", 3'd3, 2'd0, 1'b0, 1'b0);
        tick();
        muldiv_start_i = 0;
        for (int c = 1; c <= 9; c++) begin
            bus_wait_i = (c == 5);
            look($sformatf("md.c%0d", c), (c == 5) ? 3'd4 : 3'd3, 2'd2, 1'b0, 1'b0);
            tick();
        end
        bus_wait_i = 0; muldiv_done_i = 1;
        look("md.c10", 3'd0, 2'd2, 1'b0, 1'b0);
        tick();
        muldiv_done_i = 0;
        look("md.after", 3'd0, 2'd0, 1'b0, 1'b0);
        tick();

        // Mul/div timeout
        muldiv_start_i = 1;
        look("to.c0", 3'd3, 2'd0, 1'b0, 1'b0);
        tick();
        muldiv_start_i = 0;
        for (int c = 1; c <= 65; c++) begin
            @(negedge clk);
            chk($sformatf("to.c%0d.level", c), {61'd0, pipe_hold_en_o}, 64'd3);
            chk($sformatf("to.c%0d.timeout", c), {63'd0, timeout_o}, 64'd0);
            tick();
        end
        look("to.c66", 3'd0, 2'd2, 1'b0, 1'b1);
        tick();
        look("to.after", 3'd0, 2'd0, 1'b0, 1'b0);
        tick();

        // Jump and start together: jump wins, mul/div never entered
        jump_req_i = 1; muldiv_start_i = 1; jump_addr_i = 64'hABCD_0000;
        look("js0", 3'd3, 2'd0, 1'b1, 1'b0);
        tick();
        idle_in();
        look("js1", 3'd3, 2'd1, 1'b0, 1'b0);
        tick();
        for (int c = 2; c <= 4; c++) begin
            look($sformatf("js%0d", c), 3'd0, 2'd0, 1'b0, 1'b0);
            tick();
        end

        // Bus wait 4 cycles with load_use held: load_use ignored while waiting
        load_use_i = 1; bus_wait_i = 1;
        look("bw0", 3'd4, 2'd0, 1'b0, 1'b0);
        tick();
        for (int c = 1; c <= 3; c++) begin
            look($sformatf("bw%0d", c), 3'd4, 2'd3, 1'b0, 1'b0);
            tick();
        end
        bus_wait_i = 0;
        look("bw4", 3'd0, 2'd3, 1'b0, 1'b0);
        tick();
        // Back in IDLE, load_use alone bubbles IF/ID without a state change
        look("lu0", 3'd2, 2'd0, 1'b0, 1'b0);
        tick();
        load_use_i = 0;
        look("lu1", 3'd0, 2'd0, 1'b0, 1'b0);
        tick();

        // Start beats bus_wait
        muldiv_start_i = 1; bus_wait_i = 1;
        look("pr0", 3'd3, 2'd0, 1'b0, 1'b0);
        tick();
        idle_in(); muldiv_done_i = 1;
        look("pr1", 3'd0, 2'd2, 1'b0, 1'b0);
        tick();
        idle_in();

        // Async reset mid-mul/div at count 20, then a fresh op counts from 1
        muldiv_start_i = 1;
        tick();
        muldiv_start_i = 0;
        repeat (19) tick();
        @(negedge clk);
        chk("rs.pre.state", {62'd0, state_o}, 64'd2);
        rst = 1'b1;
        #1;
        chk("rs.async.level", {61'd0, pipe_hold_en_o}, 64'd0);
        chk("rs.async.state", {62'd0, state_o}, 64'd0);
        chk("rs.async.jump_en", {63'd0, jump_en_o}, 64'd0);
        chk("rs.async.addr", jump_addr_o, 64'h0);
        tick();
        rst = 1'b0;
        muldiv_start_i = 1;
        look("rs.c0", 3'd3, 2'd0, 1'b0, 1'b0);
        tick();
        muldiv_start_i = 0;
        for (int c = 1; c <= 65; c++) begin
            @(negedge clk);
            chk($sformatf("rs.c%0d.timeout", c), {63'd0, timeout_o}, 64'd0);
            tick();
        end
        look("rs.c66", 3'd0, 2'd2, 1'b0, 1'b1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
